change_dispense: RTL and testbench

CHANGE_DISPENSE -- requirements
Module: change_dispense

---
 rtl/change_pkg.sv | 46 ++++
 rtl/coin_select.sv | 45 ++++
 rtl/change_dispense.sv | 158 +++++++++++++++
 tb/tb_change_dispense.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/change_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : change_pkg
//  Description : Shared constants and types for the change dispenser:
//                coin values, one-hot coin bit positions and the payout
//                state enumeration.
//  Config      : CHANGE_COIN100_EN adds the 100-unit coin (one more one-hot
//                bit in coin_oh_t).
//  Revision    : 1.0 - initial release
// ============================================================================
package change_pkg;

    // Coin values in currency units
    localparam logic [7:0] C_COIN_1   = 8'd1;
    localparam logic [7:0] C_COIN_5   = 8'd5;
    localparam logic [7:0] C_COIN_10  = 8'd10;
    localparam logic [7:0] C_COIN_50  = 8'd50;
    localparam logic [7:0] C_COIN_100 = 8'd100;

    // Bit positions inside the one-hot coin vector
    localparam int C_IDX_1   = 0;
    localparam int C_IDX_5   = 1;
    localparam int C_IDX_10  = 2;
    localparam int C_IDX_50  = 3;
    localparam int C_IDX_100 = 4;

    // The vector only carries a 100-unit bit when that coin exists, so a
    // disabled build has no dangling register bit.
`ifdef CHANGE_COIN100_EN
    localparam int C_NUM_COINS = 5;
`else
    localparam int C_NUM_COINS = 4;
`endif

    typedef logic [C_NUM_COINS-1:0] coin_oh_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_PULSE  = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage : change_pkg
`default_nettype wire

// File: rtl/coin_select.sv
`default_nettype none
// ============================================================================
//  Module      : coin_select
//  Description : Combinational greedy coin chooser. Picks the largest
//                enabled denomination that does not exceed remain_i.
//  Config      : CHANGE_COIN100_EN enables the 100-unit denomination.
//  Ports       : remain_i   - amount still owed (8 bit)
//                coin_oh_o  - one-hot coin choice (all zero when remain_i==0)
//                coin_val_o - value of the chosen coin (0 when none)
//  Revision    : 1.0 - initial release
// ============================================================================
module coin_select
    import change_pkg::*;
(
    input  logic [7:0] remain_i,
    output coin_oh_t   coin_oh_o,
    output logic [7:0] coin_val_o
);

    always_comb begin
        coin_oh_o  = '0;
        coin_val_o = 8'd0;
`ifdef CHANGE_COIN100_EN
        if (remain_i >= C_COIN_100) begin
            coin_oh_o[C_IDX_100] = 1'b1;
            coin_val_o           = C_COIN_100;
        end else
`endif
        if (remain_i >= C_COIN_50) begin
            coin_oh_o[C_IDX_50] = 1'b1;
            coin_val_o          = C_COIN_50;
        end else if (remain_i >= C_COIN_10) begin
            coin_oh_o[C_IDX_10] = 1'b1;
            coin_val_o          = C_COIN_10;
        end else if (remain_i >= C_COIN_5) begin
            coin_oh_o[C_IDX_5] = 1'b1;
            coin_val_o         = C_COIN_5;
        end else if (remain_i >= C_COIN_1) begin
            coin_oh_o[C_IDX_1] = 1'b1;
            coin_val_o         = C_COIN_1;
        end
    end

endmodule : coin_select
`default_nettype wire

// File: rtl/change_dispense.sv
`default_nettype none
// ============================================================================
//  Module      : change_dispense
//  Description : Pays out a requested amount as a sequence of one-cycle coin
//                pulses using greedy selection. Each coin occupies
//                PULSE + COIN_GAP idle cycles + SELECT = 2+COIN_GAP cycles.
//  Config      : CHANGE_COIN100_EN adds the 100-unit coin and the co100 port.
//  Parameters  : COIN_GAP - idle cycles after each coin pulse (0 allowed)
//  Ports       : clk, rst_n (async, active-low)
//                start, amount  - payout request, sampled only in IDLE
//                co1..co50(,co100) - registered one-cycle coin pulses
//                remain         - amount still to be dispensed
//                busy           - high whenever not IDLE
//                done           - one-cycle pulse in the DONE state
//  Revision    : 1.0 - initial release
// ============================================================================
module change_dispense
    import change_pkg::*;
#(
    parameter int COIN_GAP = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] amount,
    output logic       co1,
    output logic       co5,
    output logic       co10,
    output logic       co50,
`ifdef CHANGE_COIN100_EN
    output logic       co100,
`endif
    output logic [7:0] remain,
    output logic       busy,
    output logic       done
);

    // Gap counter sized to count 0..COIN_GAP-1; kept at 1 bit when unused.
    localparam int             GW           = (COIN_GAP > 1) ? $clog2(COIN_GAP) : 1;
    localparam int             GAP_LAST_INT = (COIN_GAP > 0) ? (COIN_GAP - 1) : 0;
    localparam logic [GW-1:0]  GAP_LAST     = GW'(GAP_LAST_INT);

    state_t         state_q, state_d;
    logic [7:0]     remain_q, remain_d;
    coin_oh_t       coin_q, coin_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [GW-1:0]  gap_cnt_q, gap_cnt_d;

    coin_oh_t       w_coin_oh;
    logic [7:0]     w_coin_val;

    coin_select u_coin_select (
        .remain_i   (remain_q),
        .coin_oh_o  (w_coin_oh),
        .coin_val_o (w_coin_val)
    );

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            remain_q  <= 8'd0;
            coin_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            remain_q  <= remain_d;
            coin_q    <= coin_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (remain_q == 8'd0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (COIN_GAP > 0) begin
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_SELECT;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_SELECT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next values. Every output is computed from the
    // transition being taken so that it is registered alongside the state.
    // ------------------------------------------------------------------
    always_comb begin
        remain_d  = remain_q;
        coin_d    = '0;
        gap_cnt_d = '0;
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);

        if ((state_q == ST_IDLE) && start) begin
            remain_d = amount;
        end

        // Entering PULSE: the coin and the reduced remain appear together.
        // The chooser never returns a coin larger than remain_q.
        if ((state_q == ST_SELECT) && (remain_q != 8'd0)) begin
            remain_d = remain_q - w_coin_val;
            coin_d   = w_coin_oh;
        end

        if ((state_q == ST_GAP) && (state_d == ST_GAP)) begin
            gap_cnt_d = gap_cnt_q + GW'(1);
        end
    end

    assign co1    = coin_q[C_IDX_1];
    assign co5    = coin_q[C_IDX_5];
    assign co10   = coin_q[C_IDX_10];
    assign co50   = coin_q[C_IDX_50];
`ifdef CHANGE_COIN100_EN
    assign co100  = coin_q[C_IDX_100];
`endif
    assign remain = remain_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule : change_dispense
`default_nettype wire

// File: tb/tb_change_dispense.sv
`default_nettype none
// ============================================================================
//  Module      : tb_change_dispense
//  Description : Directed bench for change_dispense. Instance A uses
//                COIN_GAP=2, instance B uses COIN_GAP=0. Expected coin
//                sequences are hand-computed; timing is checked against the
//                2+COIN_GAP coin period.
//  Config      : CHANGE_COIN100_EN selects the expectations for 100-unit coins.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_change_dispense;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic [7:0] amount = 8'd0;

    logic       co1_a, co5_a, co10_a, co50_a, co100_a, busy_a, done_a;
    logic       co1_b, co5_b, co10_b, co50_b, co100_b, busy_b, done_b;
    logic [7:0] remain_a, remain_b;

    int checks = 0;
    int errors = 0;
    bit sel_b  = 1'b0;

    always #5 clk = ~clk;

    change_dispense #(.COIN_GAP(2)) dut_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_a),
        .amount (amount),
        .co1    (co1_a),
        .co5    (co5_a),
        .co10   (co10_a),
        .co50   (co50_a),
`ifdef CHANGE_COIN100_EN
        .co100  (co100_a),
`endif
        .remain (remain_a),
        .busy   (busy_a),
        .done   (done_a)
    );

    change_dispense #(.COIN_GAP(0)) dut_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_b),
        .amount (amount),
        .co1    (co1_b),
        .co5    (co5_b),
        .co10   (co10_b),
        .co50   (co50_b),
`ifdef CHANGE_COIN100_EN
        .co100  (co100_b),
`endif
        .remain (remain_b),
        .busy   (busy_b),
        .done   (done_b)
    );

`ifndef CHANGE_COIN100_EN
    assign co100_a = 1'b0;
    assign co100_b = 1'b0;
`endif

    // Observed view of the instance under test
    int         obs_val, obs_cnt;
    logic [7:0] obs_remain;
    logic       obs_busy, obs_done;

    always_comb begin
        if (sel_b) begin
            obs_val = (co1_b ? 1 : 0) + (co5_b ? 5 : 0) + (co10_b ? 10 : 0) +
                      (co50_b ? 50 : 0) + (co100_b ? 100 : 0);
            obs_cnt = int'(co1_b) + int'(co5_b) + int'(co10_b) + int'(co50_b) + int'(co100_b);
            obs_remain = remain_b;
            obs_busy   = busy_b;
            obs_done   = done_b;
        end else begin
            obs_val = (co1_a ? 1 : 0) + (co5_a ? 5 : 0) + (co10_a ? 10 : 0) +
                      (co50_a ? 50 : 0) + (co100_a ? 100 : 0);
            obs_cnt = int'(co1_a) + int'(co5_a) + int'(co10_a) + int'(co50_a) + int'(co100_a);
            obs_remain = remain_a;
            obs_busy   = busy_a;
            obs_done   = done_a;
        end
    end

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Everything observable is zero on both instances.
    task automatic chk_all_zero(input string tag);
        chk({tag, "/a_outputs"}, {co1_a, co5_a, co10_a, co50_a, co100_a, busy_a, done_a, remain_a}, 32'd0);
        chk({tag, "/b_outputs"}, {co1_b, co5_b, co10_b, co50_b, co100_b, busy_b, done_b, remain_b}, 32'd0);
    endtask

    // One payout: start presented for one cycle, then coin values, coin
    // spacing, remain, done timing and the return to idle are checked.
    task automatic run(input int g, input int amt, input int exp_c[8], input int n,
                       input int inject_cyc, input string tag);
        int k    = 0;
        int last = 0;
        int sum  = 0;
        bit fin  = 1'b0;
        sel_b = (g == 0);
        @(negedge clk);
        amount = 8'(amt);
        if (g == 0) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        amount  = 8'hA5;
        chk({tag, "/select_busy"},   32'(obs_busy),   32'd1);
        chk({tag, "/select_remain"}, 32'(obs_remain), 32'(amt));
        for (int cyc = 1; cyc <= 400; cyc++) begin
            if (cyc == inject_cyc) begin
                start_a = 1'b1;
                start_b = 1'b1;
                amount  = 8'd10;
            end else begin
                start_a = 1'b0;
                start_b = 1'b0;
            end
            @(posedge clk); #1;
            if (obs_cnt != 0) begin
                chk({tag, "/onehot"}, 32'(obs_cnt), 32'd1);
                chk({tag, "/coin"},   32'(obs_val), (k < n) ? 32'(exp_c[k]) : 32'd0);
                chk({tag, "/coin_cycle"}, 32'(cyc), (k == 0) ? 32'd1 : 32'(last + g + 2));
                sum += obs_val;
                chk({tag, "/remain"}, 32'(obs_remain), 32'(amt - sum));
                last = cyc;
                k++;
            end
            if (obs_done) begin
                chk({tag, "/coin_count"}, 32'(k), 32'(n));
                chk({tag, "/done_cycle"}, 32'(cyc), (n == 0) ? 32'd1 : 32'(last + g + 2));
                chk({tag, "/done_busy"}, 32'(obs_busy), 32'd1);
                fin = 1'b1;
                break;
            end
        end
        start_a = 1'b0;
        start_b = 1'b0;
        chk({tag, "/done_seen"}, 32'(fin), 32'd1);
        @(posedge clk); #1;
        chk({tag, "/idle_state"}, {obs_done, obs_busy, obs_remain}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("post_reset_idle");

        // Greedy mix with coin gap 2
        run(2, 87, '{50, 10, 10, 10, 5, 1, 1, 0}, 7, 0, "amt87");

        // Maximum amount
`ifdef CHANGE_COIN100_EN
        run(2, 255, '{100, 100, 50, 5, 0, 0, 0, 0}, 4, 0, "amt255");
`else
        run(2, 255, '{50, 50, 50, 50, 50, 5, 0, 0}, 6, 0, "amt255");
`endif

        // Zero amount: no coins, done right after SELECT
        run(2, 0, '{0, 0, 0, 0, 0, 0, 0, 0}, 0, 0, "amt0");

        // New start while busy must be ignored
        run(2, 60, '{50, 10, 0, 0, 0, 0, 0, 0}, 2, 2, "amt60_restart");

        // Reset in the middle of the second coin of a 200 payout
        sel_b = 1'b0;
        @(negedge clk);
        amount  = 8'd200;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        begin
            int pulses = 0;
            for (int c = 0; c < 40 && pulses < 2; c++) begin
                @(posedge clk); #1;
                if (obs_cnt != 0) pulses++;
            end
            chk("amt200/second_coin_seen", 32'(pulses), 32'd2);
        end
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_all_zero("reset_release");
        // Start presented in the first cycle after release
        run(2, 5, '{5, 0, 0, 0, 0, 0, 0, 0}, 1, 0, "after_reset_amt5");

        // Coin gap 0
        run(0, 16, '{10, 5, 1, 0, 0, 0, 0, 0}, 3, 0, "gap0_amt16");
        run(0, 1,  '{1, 0, 0, 0, 0, 0, 0, 0}, 1, 0, "gap0_amt1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_change_dispense
`default_nettype wire
